// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
// Default cycle counts assume a 50 MHz clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int unsigned DB_CYCLES_DEF      = 500000;    // 10 ms
  localparam int unsigned RPT_DLY_CYCLES_DEF = 25000000;  // 500 ms
  localparam int unsigned RPT_CYCLES_DEF     = 5000000;   // 100 ms

  // Counter width able to hold 0 .. max(a, b)-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, press/release strobes
// and the auto-repeat state machine.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DB_CYCLES_DEF,
  parameter int unsigned RPT_DLY_CYCLES = RPT_DLY_CYCLES_DEF,
  parameter int unsigned RPT_CYCLES     = RPT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_n,
  input  logic rpt_en,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int unsigned DbW  = cnt_width(DB_CYCLES, 1);
  localparam int unsigned RptW = cnt_width(RPT_DLY_CYCLES, RPT_CYCLES);

  logic            sync1_q, sync2_q, sync;
  logic            stable_q, stable_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            rise, fall;
  logic            press_q, rel_q, rpt_q, rpt_d;
  rpt_state_t      state_q, state_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;

  assign sync = ~sync2_q;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync != stable_q) begin
      if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
        stable_d = sync;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Edges are taken from the next-state level so strobes line up with the level change.
  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise && rpt_en) begin
          state_d   = DELAY;
          rpt_cnt_d = '0;
        end
      end
      DELAY: begin
        if (rpt_cnt_q == RptW'(RPT_DLY_CYCLES - 1)) begin
          state_d   = REPEAT;
          rpt_cnt_d = '0;
          rpt_d     = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RptW'(1);
        end
      end
      REPEAT: begin
        if (rpt_cnt_q == RptW'(RPT_CYCLES - 1)) begin
          rpt_cnt_d = '0;
          rpt_d     = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RptW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
    // Release wins over a coincident repeat terminal count.
    if (fall) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
      rpt_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      rpt_q     <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      sync1_q   <= push_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= rise;
      rel_q     <= fall;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign lvl   = stable_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rpt   = rpt_q;

endmodule

// File: rtl/key_debounce_rpt.sv
// Conditions the raw active-low push-buttons into clean levels plus
// press, release and auto-repeat strobes, one independent channel per key.
module key_debounce_rpt
  import key_pkg::*;
#(
  parameter int unsigned     NKEY           = 4,
  parameter int unsigned     DB_CYCLES      = DB_CYCLES_DEF,
  parameter int unsigned     RPT_DLY_CYCLES = RPT_DLY_CYCLES_DEF,
  parameter int unsigned     RPT_CYCLES     = RPT_CYCLES_DEF,
  parameter logic [NKEY-1:0] RPT_MASK       = 4'b0111
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NKEY-1:0] PUSH_N,
  output logic [NKEY-1:0] KEY_LVL,
  output logic [NKEY-1:0] KEY_PRESS,
  output logic [NKEY-1:0] KEY_REL,
  output logic [NKEY-1:0] KEY_RPT
);

  for (genvar i = 0; i < NKEY; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES      (DB_CYCLES),
      .RPT_DLY_CYCLES (RPT_DLY_CYCLES),
      .RPT_CYCLES     (RPT_CYCLES)
    ) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .push_n (PUSH_N[i]),
      .rpt_en (RPT_MASK[i]),
      .lvl    (KEY_LVL[i]),
      .press  (KEY_PRESS[i]),
      .rel    (KEY_REL[i]),
      .rpt    (KEY_RPT[i])
    );
  end

endmodule
